// File: rtl/pisim_pkg.sv
// Shared screen geometry, Q3.13 scale and divider state encodings for the pi estimator
// and the circle checker, so the inside rule is defined in one place.
package pisim_pkg;

  localparam int CX     = 240;
  localparam int CY     = 240;
  localparam int RADIUS = 240;
  localparam int SQ_LIM = 480;

  // 4.0 in unsigned Q3.13; the quotient width follows from it.
  localparam logic [15:0] Q313_FOUR = 16'h8000;
  localparam int          QUOT_W    = $bits(Q313_FOUR);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/pi_estimator_frac_divider.sv
// Sequential restoring divider: quot = floor(num * 2^(QUOT_W-1) / den), one bit per cycle,
// for num <= den. Start is accepted only in IDLE; done pulses one cycle as the result lands.
module frac_divider
  import pisim_pkg::*;
#(
  parameter int CNT_W = 20
) (
  input  logic              clk10,
  input  logic              reset,
  input  logic              i_start,
  input  logic [CNT_W-1:0]  i_num,
  input  logic [CNT_W-1:0]  i_den,
  output logic              o_busy,
  output logic              o_done,
  output logic [QUOT_W-1:0] o_quot
);

  div_state_e        r_state;
  div_state_e        w_state_nxt;
  logic [CNT_W:0]    r_rem;
  logic [CNT_W:0]    r_den;
  logic [QUOT_W-1:0] r_quot;
  logic [QUOT_W-1:0] r_result;
  logic              r_done;
  logic [3:0]        r_bit_cnt;
  logic              w_ge;
  logic              w_last;
  logic [CNT_W:0]    w_rem_sub;

  always_ff @(posedge clk10) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (i_start) w_state_nxt = DIV;
      DIV:     if (w_last)  w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // rem stays below den after each step, so the shift never loses its top bit.
  assign w_ge      = (r_rem >= r_den);
  assign w_rem_sub = w_ge ? (r_rem - r_den) : r_rem;
  assign w_last    = (r_bit_cnt == 4'd0);

  always_ff @(posedge clk10) begin
    if (reset) begin
      r_rem     <= '0;
      r_den     <= '0;
      r_quot    <= '0;
      r_result  <= '0;
      r_done    <= 1'b0;
      r_bit_cnt <= 4'd0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_rem     <= {1'b0, i_num};
            r_den     <= {1'b0, i_den};
            r_quot    <= '0;
            r_bit_cnt <= 4'(QUOT_W - 1);
          end
        end
        DIV: begin
          r_quot    <= {r_quot[QUOT_W-2:0], w_ge};
          r_rem     <= w_rem_sub << 1;
          r_bit_cnt <= r_bit_cnt - 4'd1;
        end
        DONE: begin
          r_result <= r_quot;
          r_done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_busy = (r_state == DIV) || (r_state == DONE);
  assign o_done = r_done;
  assign o_quot = r_result;

endmodule

// File: rtl/pi_estimator.sv
// Monte Carlo pi accumulator: classifies LFSR points against the display circle, counts
// inside/total and republishes 4*inside/total in Q3.13 after every count change.
module pi_estimator #(
  parameter int CNT_W  = 20,
  parameter int CX     = pisim_pkg::CX,
  parameter int CY     = pisim_pkg::CY,
  parameter int RADIUS = pisim_pkg::RADIUS,
  parameter int SQ_LIM = pisim_pkg::SQ_LIM
) (
  input  logic             clk10,
  input  logic             reset,
  input  logic             sample_valid,
  input  logic [8:0]       sample_x,
  input  logic [8:0]       sample_y,
  output logic [CNT_W-1:0] inside_count,
  output logic [CNT_W-1:0] total_count,
  output logic             saturated,
  output logic [15:0]      pi_est,
  output logic             pi_valid,
  output logic             busy
);

  localparam logic [17:0] R_SQ = 18'(RADIUS * RADIUS);

  logic                    r_s1_valid;
  logic                    r_s1_discard;
  logic signed [9:0]       r_s1_dx;
  logic signed [9:0]       r_s1_dy;
  logic                    r_s2_valid;
  logic                    r_s2_inside;
  logic signed [17:0]      w_dx_ext;
  logic signed [17:0]      w_dy_ext;
  logic signed [17:0]      w_dx_sq;
  logic signed [17:0]      w_dy_sq;
  logic [17:0]             w_dist;
  logic [CNT_W-1:0]        r_inside;
  logic [CNT_W-1:0]        r_total;
  logic                    r_pending;
  logic                    w_sat;
  logic                    w_accept;
  logic                    w_start;
  logic                    w_busy;
  logic                    w_done;
  logic [15:0]             w_quot;

  always_ff @(posedge clk10) begin
    if (reset) begin
      r_s1_valid   <= 1'b0;
      r_s1_discard <= 1'b0;
      r_s1_dx      <= '0;
      r_s1_dy      <= '0;
    end else begin
      r_s1_valid   <= sample_valid;
      r_s1_discard <= ({1'b0, sample_x} >= 10'(SQ_LIM)) || ({1'b0, sample_y} >= 10'(SQ_LIM));
      r_s1_dx      <= {1'b0, sample_x} - 10'(CX);
      r_s1_dy      <= {1'b0, sample_y} - 10'(CY);
    end
  end

  // Squares of |d| <= 271 fit 17 bits, their sum fits 18 bits unsigned.
  assign w_dx_ext = 18'(r_s1_dx);
  assign w_dy_ext = 18'(r_s1_dy);
  assign w_dx_sq  = w_dx_ext * w_dx_ext;
  assign w_dy_sq  = w_dy_ext * w_dy_ext;
  assign w_dist   = $unsigned(w_dx_sq) + $unsigned(w_dy_sq);

  always_ff @(posedge clk10) begin
    if (reset) begin
      r_s2_valid  <= 1'b0;
      r_s2_inside <= 1'b0;
    end else begin
      r_s2_valid  <= r_s1_valid && !r_s1_discard;
      r_s2_inside <= (w_dist < R_SQ);
    end
  end

  assign w_sat    = (r_total == {CNT_W{1'b1}});
  assign w_accept = r_s2_valid && !w_sat;
  // Snapshot uses the pre-update counts; a same-cycle accept keeps pending set.
  assign w_start  = r_pending && (r_total != '0) && !w_busy;

  always_ff @(posedge clk10) begin
    if (reset) begin
      r_inside  <= '0;
      r_total   <= '0;
      r_pending <= 1'b0;
    end else begin
      if (w_accept) begin
        r_total  <= r_total + {{(CNT_W-1){1'b0}}, 1'b1};
        r_inside <= r_inside + {{(CNT_W-1){1'b0}}, r_s2_inside};
      end
      if (w_accept)     r_pending <= 1'b1;
      else if (w_start) r_pending <= 1'b0;
    end
  end

  frac_divider #(
    .CNT_W (CNT_W)
  ) u_div (
    .clk10   (clk10),
    .reset   (reset),
    .i_start (w_start),
    .i_num   (r_inside),
    .i_den   (r_total),
    .o_busy  (w_busy),
    .o_done  (w_done),
    .o_quot  (w_quot)
  );

  assign inside_count = r_inside;
  assign total_count  = r_total;
  assign saturated    = w_sat;
  assign pi_est       = w_quot;
  assign pi_valid     = w_done;
  assign busy         = w_busy;

endmodule

// File: tb/tb_pi_estimator.sv
// Directed bench for pi_estimator: single-sample vector table plus hand-written
// back-to-back, saturation (CNT_W=4) and reset-during-division sequences.
module tb_pi_estimator;

  logic        clk10 = 1'b0;
  logic        reset = 1'b1;
  logic        sample_valid = 1'b0;
  logic [8:0]  sample_x = '0;
  logic [8:0]  sample_y = '0;

  logic [19:0] in20, tot20;
  logic        sat20, pv20, busy20;
  logic [15:0] pi20;
  logic [3:0]  in4, tot4;
  logic        sat4, pv4, busy4;
  logic [15:0] pi4;

  int n_checks = 0;
  int n_err    = 0;

  always #50 clk10 = ~clk10;

  pi_estimator #(.CNT_W(20)) dut (
    .clk10(clk10), .reset(reset), .sample_valid(sample_valid),
    .sample_x(sample_x), .sample_y(sample_y),
    .inside_count(in20), .total_count(tot20), .saturated(sat20),
    .pi_est(pi20), .pi_valid(pv20), .busy(busy20)
  );

  pi_estimator #(.CNT_W(4)) dut4 (
    .clk10(clk10), .reset(reset), .sample_valid(sample_valid),
    .sample_x(sample_x), .sample_y(sample_y),
    .inside_count(in4), .total_count(tot4), .saturated(sat4),
    .pi_est(pi4), .pi_valid(pv4), .busy(busy4)
  );

  typedef struct {
    logic [8:0]  x;
    logic [8:0]  y;
    logic [19:0] exp_in;
    logic [19:0] exp_tot;
    logic        exp_pv;
    logic [15:0] exp_pi;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk10);
    reset = 1'b1;
    sample_valid = 1'b0;
    repeat (2) @(posedge clk10);
    @(negedge clk10);
    reset = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in20"},  in20,  0);
    check({tag, "_tot20"}, tot20, 0);
    check({tag, "_sat20"}, sat20, 0);
    check({tag, "_pi20"},  pi20,  0);
    check({tag, "_pv20"},  pv20,  0);
    check({tag, "_busy20"}, busy20, 0);
    check({tag, "_in4"},   in4,   0);
    check({tag, "_tot4"},  tot4,  0);
    check({tag, "_pi4"},   pi4,   0);
    check({tag, "_pv4"},   pv4,   0);
    check({tag, "_busy4"}, busy4, 0);
  endtask

  initial begin
    #(100 * 20000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic early;
    logic seen;
    int   npulse;
    logic [15:0] first_pi;
    logic [8:0]  sx, sy;

    vecs[0] = '{9'd240, 9'd240, 20'd1, 20'd1, 1'b1, 16'h8000};
    vecs[1] = '{9'd0,   9'd0,   20'd0, 20'd1, 1'b1, 16'h0000};
    vecs[2] = '{9'd0,   9'd240, 20'd0, 20'd1, 1'b1, 16'h0000};
    vecs[3] = '{9'd480, 9'd10,  20'd0, 20'd0, 1'b0, 16'h0000};
    vecs[4] = '{9'd511, 9'd511, 20'd0, 20'd0, 1'b0, 16'h0000};
    vecs[5] = '{9'd10,  9'd480, 20'd0, 20'd0, 1'b0, 16'h0000};
    vecs[6] = '{9'd479, 9'd240, 20'd1, 20'd1, 1'b1, 16'h8000};
    vecs[7] = '{9'd240, 9'd479, 20'd1, 20'd1, 1'b1, 16'h8000};
    vecs[8] = '{9'd479, 9'd479, 20'd0, 20'd1, 1'b1, 16'h0000};

    // Reset state and quiet idle.
    do_reset();
    #1;
    check_all_zero("rst");
    seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk10); #1;
      if (pv20 || busy20 || pv4 || busy4) seen = 1'b1;
    end
    check("idle_no_activity", seen, 0);

    // Single-sample vectors with exact latency.
    for (int v = 0; v < 9; v++) begin
      do_reset();
      sample_valid = 1'b1;
      sample_x = vecs[v].x;
      sample_y = vecs[v].y;
      @(posedge clk10);
      @(negedge clk10);
      sample_valid = 1'b0;
      early = 1'b0;
      for (int k = 1; k <= 20; k++) begin
        @(posedge clk10); #1;
        if (k == 1) check($sformatf("v%0d_tot_c1", v), tot20, 0);
        if (k == 2) check($sformatf("v%0d_tot_c2", v), tot20, vecs[v].exp_tot);
        if (k < 20 && (pv20 || pi20 != 16'h0)) early = 1'b1;
      end
      check($sformatf("v%0d_early", v), early, 0);
      check($sformatf("v%0d_pv", v), pv20, vecs[v].exp_pv);
      check($sformatf("v%0d_pi", v), pi20, vecs[v].exp_pi);
      check($sformatf("v%0d_in", v), in20, vecs[v].exp_in);
      check($sformatf("v%0d_tot", v), tot20, vecs[v].exp_tot);
      check($sformatf("v%0d_busy", v), busy20, 0);
      @(posedge clk10); #1;
      check($sformatf("v%0d_pv_drop", v), pv20, 0);
    end

    // Back-to-back samples; the second division must see all four.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: begin sx = 9'd240; sy = 9'd240; end
        1: begin sx = 9'd100; sy = 9'd240; end
        2: begin sx = 9'd240; sy = 9'd100; end
        default: begin sx = 9'd0; sy = 9'd0; end
      endcase
      sample_valid = 1'b1;
      sample_x = sx;
      sample_y = sy;
      @(negedge clk10);
    end
    sample_valid = 1'b0;
    npulse = 0;
    first_pi = '0;
    for (int k = 0; k < 80; k++) begin
      @(posedge clk10); #1;
      if (pv20) begin
        npulse++;
        if (npulse == 1) first_pi = pi20;
      end
    end
    check("b2b_in", in20, 3);
    check("b2b_tot", tot20, 4);
    check("b2b_pulses", npulse, 2);
    check("b2b_first_pi", first_pi, 16'h8000);
    check("b2b_final_pi", pi20, 16'h6000);

    // Sixteen samples: the 4-bit instance freezes at 15 and ignores the 16th (inside) point.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      sample_valid = 1'b1;
      sample_x = (i % 2 == 1) ? 9'd240 : 9'd0;
      sample_y = (i % 2 == 1) ? 9'd240 : 9'd0;
      @(negedge clk10);
    end
    sample_valid = 1'b0;
    repeat (120) @(posedge clk10);
    #1;
    check("sat4_tot", tot4, 15);
    check("sat4_flag", sat4, 1);
    check("sat4_in", in4, 7);
    check("sat4_pi", pi4, 16'h3BBB);
    check("sat20_tot", tot20, 16);
    check("sat20_in", in20, 8);
    check("sat20_flag", sat20, 0);
    check("sat20_pi", pi20, 16'h4000);

    // Reset in the middle of a division.
    do_reset();
    sample_valid = 1'b1;
    sample_x = 9'd240;
    sample_y = 9'd240;
    @(posedge clk10);
    @(negedge clk10);
    sample_valid = 1'b0;
    repeat (10) @(posedge clk10);
    #1;
    check("middiv_busy4", busy4, 1);
    check("middiv_busy20", busy20, 1);
    @(negedge clk10);
    reset = 1'b1;
    @(posedge clk10); #1;
    check_all_zero("middiv");
    check("middiv_sat4", sat4, 0);
    @(negedge clk10);
    reset = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk10); #1;
      if (pv20 || pv4 || busy20 || busy4) seen = 1'b1;
    end
    check("middiv_no_pulse", seen, 0);
    check("middiv_tot_after", tot20, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
